// File: rtl/avalon_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avalon_mon_pkg                                            |
// | Purpose  : Shared types and constants for the Avalon-MM bus monitor: |
// |            FSM state encoding, error codes, counter width and a      |
// |            saturating-increment helper.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package avalon_mon_pkg;

  // Width of cycle_count, rd_count and wr_count.
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_RUN        = 2'd1,
    ST_DONE       = 2'd2,
    ST_FAIL       = 2'd3
  } mon_state_t;

  // Error codes; a lower value has higher priority on the same cycle.
  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_NOSTART = 4'd1;
  localparam logic [3:0] ERR_RW_BOTH = 4'd2;
  localparam logic [3:0] ERR_ALIGN   = 4'd3;
  localparam logic [3:0] ERR_BE_ZERO = 4'd4;
  localparam logic [3:0] ERR_HOLD    = 4'd5;
  localparam logic [3:0] ERR_STALL   = 4'd6;
  localparam logic [3:0] ERR_TIMEOUT = 4'd7;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_bus_monitor_req_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avalon_req_tracker                                        |
// | Purpose  : Watches one Avalon-MM request across waitrequest stalls.  |
// |            Captures the request while it is stalled, flags any       |
// |            change to it (including dropping it) on the next cycle,   |
// |            and flags a stall longer than MAX_WAIT cycles.            |
// | Ports    : clk, reset (async, active-low)                            |
// |            read, write, waitrequest, address, byteenable, writedata  |
// |            hold_err  - request changed/dropped while stalled         |
// |            stall_err - stall would exceed MAX_WAIT consecutive cycles|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module avalon_req_tracker #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic                waitrequest,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic                hold_err,
  output logic                stall_err
);

  // One spare value so the counter can represent MAX_WAIT itself.
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic                req;
  logic                stalled;
  logic                prev_stall;
  logic                hold_read;
  logic                hold_write;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W/8-1:0] hold_be;
  logic [DATA_W-1:0]   hold_wdata;
  logic [WAIT_W-1:0]   wait_cnt;

  assign req     = read | write;
  assign stalled = req & waitrequest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_stall <= 1'b0;
      hold_read  <= 1'b0;
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_be    <= '0;
      hold_wdata <= '0;
      wait_cnt   <= '0;
    end else begin
      prev_stall <= stalled;
      if (stalled) begin
        hold_read  <= read;
        hold_write <= write;
        hold_addr  <= address;
        hold_be    <= byteenable;
        hold_wdata <= writedata;
      end
      // Any cycle that is not a stall (a transfer or an idle bus) ends the run.
      if (!stalled) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // A dropped request shows up as read/write differing from the held copy.
  always_comb begin
    hold_err  = prev_stall &&
                ((read != hold_read) || (write != hold_write) ||
                 (address != hold_addr) || (byteenable != hold_be) ||
                 (write && (writedata != hold_wdata)));
    stall_err = stalled && (wait_cnt == WAIT_MAX);
  end

endmodule
`default_nettype wire

// File: rtl/avalon_bus_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avalon_bus_monitor                                        |
// | Purpose  : Watchdog/protocol checker on the CPU <-> RAM Avalon-MM    |
// |            link. Tracks the CPU run, counts RUN cycles and completed |
// |            transfers, detects protocol errors and latches a sticky   |
// |            pass/fail verdict.                                        |
// | Ports    : clk, reset (async, active-low)                            |
// |            active, register_v0           - CPU status               |
// |            address, byteenable, read, write, waitrequest, writedata |
// |                                           - monitored Avalon bus    |
// |            done, pass, err_code, err_addr, result_v0 - verdict       |
// |            cycle_count, rd_count, wr_count           - statistics    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module avalon_bus_monitor
  import avalon_mon_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int START_CYCLES   = 4,
  parameter int MAX_WAIT       = 64,
  parameter int ALIGN_BITS     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  input  logic [DATA_W-1:0]   register_v0,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                read,
  input  logic                write,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   writedata,
  output logic                done,
  output logic                pass,
  output logic [3:0]          err_code,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   result_v0,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count
);

  mon_state_t       state;
  mon_state_t       state_nx;
  logic [CNT_W-1:0] start_cnt;
  logic [3:0]       err_now;
  logic             req;
  logic             misalign;
  logic             hold_err;
  logic             stall_err;
  logic             timeout;
  logic             start_expired;

  assign req = read | write;

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign misalign = |address[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  avalon_req_tracker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_req_tracker (
    .clk         (clk),
    .reset       (reset),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .address     (address),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .hold_err    (hold_err),
    .stall_err   (stall_err)
  );

  // cycle_count already holds the previous RUN cycles, so this edge makes
  // it reach TIMEOUT_CYCLES when it currently sits one below.
  assign timeout       = active && (cycle_count >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign start_expired = !active && (start_cnt >= CNT_W'(START_CYCLES - 1));

  // Lowest error code wins when several checks fire together.
  always_comb begin
    err_now = ERR_NONE;
    if (read && write)                 err_now = ERR_RW_BOTH;
    else if (req && misalign)          err_now = ERR_ALIGN;
    else if (req && (byteenable == '0)) err_now = ERR_BE_ZERO;
    else if (hold_err)                 err_now = ERR_HOLD;
    else if (stall_err)                err_now = ERR_STALL;
    else if (timeout)                  err_now = ERR_TIMEOUT;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT_START;
    else        state <= state_nx;
  end

  // Next-state logic; an error on the finishing cycle overrides the finish.
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT_START: begin
        if (active)             state_nx = ST_RUN;
        else if (start_expired) state_nx = ST_FAIL;
      end
      ST_RUN: begin
        if (err_now != ERR_NONE) state_nx = ST_FAIL;
        else if (!active)        state_nx = ST_DONE;
      end
      ST_DONE, ST_FAIL: state_nx = state;
      default:          state_nx = ST_WAIT_START;
    endcase
  end

  // Verdict flags decoded from the registered state.
  always_comb begin
    done = (state == ST_DONE) || (state == ST_FAIL);
    pass = (state == ST_DONE);
  end

  // Counters and latched verdict data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_cnt   <= '0;
      cycle_count <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      err_code    <= ERR_NONE;
      err_addr    <= '0;
      result_v0   <= '0;
    end else begin
      if ((state == ST_WAIT_START) && !active) begin
        start_cnt <= sat_inc(start_cnt);
      end
      if (state == ST_RUN) begin
        cycle_count <= sat_inc(cycle_count);
        if (read && !waitrequest)  rd_count <= sat_inc(rd_count);
        if (write && !waitrequest) wr_count <= sat_inc(wr_count);
      end
      if ((state == ST_WAIT_START) && (state_nx == ST_FAIL)) begin
        err_code <= ERR_NOSTART;
        err_addr <= address;
      end
      if ((state == ST_RUN) && (state_nx == ST_FAIL)) begin
        err_code <= err_now;
        err_addr <= address;
      end
      if ((state == ST_RUN) && (state_nx == ST_DONE)) begin
        result_v0 <= register_v0;
      end
    end
  end

endmodule
`default_nettype wire
